// File: rtl/vend_pkg.sv
// Shared types, coin denominations and price table for the vending purchase sequencer.
package vend_pkg;

  // Coin denominations accepted by the acceptor and paid by the hopper
  localparam int unsigned COIN_1  = 1;
  localparam int unsigned COIN_5  = 5;
  localparam int unsigned COIN_10 = 10;
  localparam int unsigned COIN_50 = 50;

  // Drink prices for slots 0..3
  localparam int unsigned PRICE_0 = 10;
  localparam int unsigned PRICE_1 = 15;
  localparam int unsigned PRICE_2 = 20;
  localparam int unsigned PRICE_3 = 25;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CREDIT,
    ST_DISPENSE,
    ST_CHANGE
  } state_t;

  typedef enum logic [1:0] {
    CD_WAIT,
    CD_REQ,
    CD_GAP
  } chg_state_t;

  // Price lookup; slots beyond the table reuse the top price
  function automatic int unsigned price_of(input int unsigned slot);
    case (slot)
      0:       price_of = PRICE_0;
      1:       price_of = PRICE_1;
      2:       price_of = PRICE_2;
      default: price_of = PRICE_3;
    endcase
  endfunction

  // True when the value is a denomination the machine accepts
  function automatic logic is_denom(input int unsigned v);
    is_denom = (v == COIN_1) || (v == COIN_5) || (v == COIN_10) || (v == COIN_50);
  endfunction

  // Largest denomination not exceeding the given credit (0 when credit is 0)
  function automatic int unsigned greedy_coin(input int unsigned c);
    if (c >= COIN_50)      greedy_coin = COIN_50;
    else if (c >= COIN_10) greedy_coin = COIN_10;
    else if (c >= COIN_5)  greedy_coin = COIN_5;
    else if (c >= COIN_1)  greedy_coin = COIN_1;
    else                   greedy_coin = 0;
  endfunction

endpackage

// File: rtl/change_dispenser.sv
// Greedy change payout: requests one coin at a time from the hopper and
// reports each paid coin back to the credit owner as a decrement strobe.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int unsigned CREDIT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [CREDIT_W-1:0] credit,
  input  logic                ack,
  output logic                req,
  output logic [CREDIT_W-1:0] value,
  output logic                dec_c,
  output logic [CREDIT_W-1:0] dec_value_c,
  output logic                done_c
);

  chg_state_t cs_q, cs_d;

  // Payout state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cs_q <= CD_WAIT;
    else        cs_q <= cs_d;
  end

  // Next state: request, wait for ack, one idle gap, repeat while credit remains
  always_comb begin
    cs_d = cs_q;
    case (cs_q)
      CD_WAIT: if (start && (credit != '0)) cs_d = CD_REQ;
      CD_REQ: begin
        if (!start)   cs_d = CD_WAIT;
        else if (ack) cs_d = CD_GAP;
      end
      CD_GAP: begin
        if (!start || (credit == '0)) cs_d = CD_WAIT;
        else                           cs_d = CD_REQ;
      end
      default: cs_d = CD_WAIT;
    endcase
  end

  // Strobes back to the credit owner
  always_comb begin
    dec_c       = (cs_q == CD_REQ) && start && ack;
    dec_value_c = value;
    done_c      = start && (credit == '0) && (cs_q != CD_REQ);
  end

  // Registered hopper request; denomination chosen from the settled credit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req   <= 1'b0;
      value <= '0;
    end else begin
      req <= (cs_d == CD_REQ);
      if (cs_d != CD_REQ)      value <= '0;
      else if (cs_q != CD_REQ) value <= CREDIT_W'(greedy_coin(32'(credit)));
    end
  end

endmodule

// File: rtl/vend_sequencer.sv
// Vending purchase sequencer: owns the credit register, validates selections,
// runs the dispenser handshake and hands refunds to change_dispenser.
// Optional per-slot stock tracking is enabled with `define VEND_STOCK_EN.
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int unsigned N_DRINK      = 4,
  parameter int unsigned CREDIT_W     = 8,
`ifdef VEND_STOCK_EN
  parameter int unsigned STOCK_INIT   = 8,
`endif
  parameter int unsigned DISP_TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       coin_valid,
  input  logic [CREDIT_W-1:0]        coin_value,
  output logic                       coin_reject,
  input  logic                       sel_valid,
  input  logic [N_DRINK-1:0]         sel,
  input  logic                       cancel,
  output logic [CREDIT_W-1:0]        credit,
  output logic                       sel_error,
  output logic                       disp_req,
  output logic [$clog2(N_DRINK)-1:0] disp_slot,
  input  logic                       disp_done,
  output logic                       chg_req,
  output logic [CREDIT_W-1:0]        chg_value,
  input  logic                       chg_ack,
  output logic                       busy,
`ifdef VEND_STOCK_EN
  input  logic                       restock,
  output logic [N_DRINK-1:0]         sold_out,
`endif
  output logic                       fault
);

  localparam int unsigned SLOT_W = $clog2(N_DRINK);
  localparam int unsigned TMR_W  = $clog2(DISP_TIMEOUT + 1);
  localparam logic [CREDIT_W:0] CREDIT_MAX = {1'b0, {CREDIT_W{1'b1}}};

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [CREDIT_W-1:0] price_q, price_d;
  logic [TMR_W-1:0]    tmr_q;
  logic                coin_reject_d, sel_error_d, fault_d;

  logic                coin_ok_c;
  logic [SLOT_W-1:0]   sel_slot_c;
  logic [CREDIT_W-1:0] sel_price_c;
  logic                sel_ok_c;
  logic                stock_ok_c;
  logic                timeout_c;
  logic                dec_c;
  logic [CREDIT_W-1:0] dec_value_c;
  logic                done_c;

  assign credit = credit_q;

  // Coin acceptance: right state, real denomination, no credit overflow
  always_comb begin
    coin_ok_c = coin_valid
             && ((state_q == ST_IDLE) || (state_q == ST_CREDIT))
             && is_denom(32'(coin_value))
             && (({1'b0, credit_q} + {1'b0, coin_value}) <= CREDIT_MAX);
  end

  // Selection decode and validation against the pre-coin credit
  always_comb begin
    sel_slot_c = '0;
    for (int i = 0; i < N_DRINK; i++) begin
      if (sel[i]) sel_slot_c = SLOT_W'(i);
    end
    sel_price_c = CREDIT_W'(price_of(32'(sel_slot_c)));
    sel_ok_c    = $onehot(sel) && (sel_price_c <= credit_q) && stock_ok_c;
  end

  assign timeout_c = (tmr_q == TMR_W'(DISP_TIMEOUT - 1));

  // Main state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (coin_ok_c) state_d = ST_CREDIT;
      ST_CREDIT: begin
        if (cancel)                     state_d = ST_CHANGE;
        else if (sel_valid && sel_ok_c) state_d = ST_DISPENSE;
      end
      ST_DISPENSE: begin
        if (disp_done)      state_d = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
        else if (timeout_c) state_d = ST_CHANGE;
      end
      ST_CHANGE: if (done_c) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Credit arithmetic, purchase latch and pulse outputs
  always_comb begin
    credit_d      = credit_q;
    slot_d        = slot_q;
    price_d       = price_q;
    coin_reject_d = coin_valid && !coin_ok_c;
    sel_error_d   = 1'b0;
    fault_d       = 1'b0;
    if (coin_ok_c) credit_d = credit_q + coin_value;
    case (state_q)
      ST_CREDIT: begin
        if (!cancel && sel_valid) begin
          if (sel_ok_c) begin
            credit_d = credit_d - sel_price_c;
            slot_d   = sel_slot_c;
            price_d  = sel_price_c;
          end else begin
            sel_error_d = 1'b1;
          end
        end
      end
      ST_DISPENSE: begin
        if (!disp_done && timeout_c) begin
          fault_d  = 1'b1;
          credit_d = credit_q + price_q;
        end
      end
      ST_CHANGE: if (dec_c) credit_d = credit_q - dec_value_c;
      default: ;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_q    <= '0;
      slot_q      <= '0;
      price_q     <= '0;
      coin_reject <= 1'b0;
      sel_error   <= 1'b0;
      fault       <= 1'b0;
      disp_req    <= 1'b0;
      disp_slot   <= '0;
      busy        <= 1'b0;
    end else begin
      credit_q    <= credit_d;
      slot_q      <= slot_d;
      price_q     <= price_d;
      coin_reject <= coin_reject_d;
      sel_error   <= sel_error_d;
      fault       <= fault_d;
      disp_req    <= (state_d == ST_DISPENSE);
      disp_slot   <= (state_d == ST_DISPENSE) ? slot_d : '0;
      busy        <= (state_d inside {ST_DISPENSE, ST_CHANGE});
    end
  end

  // Dispense timer counts cycles since disp_req rose
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     tmr_q <= '0;
    else if (state_q == ST_DISPENSE) tmr_q <= tmr_q + TMR_W'(1);
    else                            tmr_q <= '0;
  end

`ifdef VEND_STOCK_EN
  localparam int unsigned STOCK_W = (STOCK_INIT > 0) ? $clog2(STOCK_INIT + 1) : 1;

  logic [STOCK_W-1:0] stock_q [N_DRINK];

  assign stock_ok_c = (stock_q[sel_slot_c] != '0);

  // Per-slot stock counters and sold-out flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_DRINK; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
      sold_out <= {N_DRINK{STOCK_INIT == 0}};
    end else begin
      for (int i = 0; i < N_DRINK; i++) begin
        if (restock && ((state_q == ST_IDLE) || (state_q == ST_CREDIT))) begin
          stock_q[i]  <= STOCK_W'(STOCK_INIT);
          sold_out[i] <= (STOCK_INIT == 0);
        end else if ((state_q == ST_DISPENSE) && disp_done && (slot_q == SLOT_W'(i))
                     && (stock_q[i] != '0)) begin
          stock_q[i]  <= stock_q[i] - STOCK_W'(1);
          sold_out[i] <= (stock_q[i] == STOCK_W'(1));
        end
      end
    end
  end
`else
  assign stock_ok_c = 1'b1;
`endif

  // Change payout engine
  change_dispenser #(
    .CREDIT_W (CREDIT_W)
  ) u_change (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (state_q == ST_CHANGE),
    .credit      (credit_q),
    .ack         (chg_ack),
    .req         (chg_req),
    .value       (chg_value),
    .dec_c       (dec_c),
    .dec_value_c (dec_value_c),
    .done_c      (done_c)
  );

endmodule

// File: tb/tb_vend_sequencer.sv
// Self-checking bench for vend_sequencer: a directed vector table plus
// hand-written sequences for overflow, timeout, reset and stock corners.
module tb_vend_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       coin_valid;
  logic [7:0] coin_value;
  logic       coin_reject;
  logic       sel_valid;
  logic [3:0] sel;
  logic       cancel;
  logic [7:0] credit;
  logic       sel_error;
  logic       disp_req;
  logic [1:0] disp_slot;
  logic       disp_done;
  logic       chg_req;
  logic [7:0] chg_value;
  logic       chg_ack;
  logic       busy;
  logic       fault;
`ifdef VEND_STOCK_EN
  logic       restock;
  logic [3:0] sold_out;
`endif

  always #5 clk = ~clk;

`ifdef VEND_STOCK_EN
  vend_sequencer #(.STOCK_INIT(1)) dut (
    .clk(clk), .rst_n(rst_n), .coin_valid(coin_valid), .coin_value(coin_value),
    .coin_reject(coin_reject), .sel_valid(sel_valid), .sel(sel), .cancel(cancel),
    .credit(credit), .sel_error(sel_error), .disp_req(disp_req), .disp_slot(disp_slot),
    .disp_done(disp_done), .chg_req(chg_req), .chg_value(chg_value), .chg_ack(chg_ack),
    .busy(busy), .restock(restock), .sold_out(sold_out), .fault(fault)
  );
`else
  vend_sequencer dut (
    .clk(clk), .rst_n(rst_n), .coin_valid(coin_valid), .coin_value(coin_value),
    .coin_reject(coin_reject), .sel_valid(sel_valid), .sel(sel), .cancel(cancel),
    .credit(credit), .sel_error(sel_error), .disp_req(disp_req), .disp_slot(disp_slot),
    .disp_done(disp_done), .chg_req(chg_req), .chg_value(chg_value), .chg_ack(chg_ack),
    .busy(busy), .fault(fault)
  );
`endif

  typedef struct {
    logic       cv;
    logic [7:0] cval;
    logic       sv;
    logic [3:0] s;
    logic       can;
    logic       dd;
    logic       ack;
    logic [7:0] e_credit;
    logic       e_rej;
    logic       e_serr;
    logic       e_dreq;
    logic [1:0] e_slot;
    logic       e_creq;
    logic [7:0] e_cval;
    logic       e_busy;
    logic       e_fault;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s [%0d]: got %0d want %0d", name, idx, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    coin_valid = 1'b0;
    coin_value = 8'd0;
    sel_valid  = 1'b0;
    sel        = 4'd0;
    cancel     = 1'b0;
    disp_done  = 1'b0;
    chg_ack    = 1'b0;
`ifdef VEND_STOCK_EN
    restock    = 1'b0;
`endif
  endtask

  task automatic add(input logic cv, input int cval, input logic sv, input logic [3:0] s,
                     input logic can, input logic dd, input logic ack,
                     input int e_credit, input logic e_rej, input logic e_serr,
                     input logic e_dreq, input int e_slot, input logic e_creq,
                     input int e_cval, input logic e_busy, input logic e_fault);
    vec_t v;
    v.cv = cv; v.cval = 8'(cval); v.sv = sv; v.s = s; v.can = can; v.dd = dd; v.ack = ack;
    v.e_credit = 8'(e_credit); v.e_rej = e_rej; v.e_serr = e_serr; v.e_dreq = e_dreq;
    v.e_slot = 2'(e_slot); v.e_creq = e_creq; v.e_cval = 8'(e_cval); v.e_busy = e_busy;
    v.e_fault = e_fault;
    tbl.push_back(v);
  endtask

  task automatic coin(input int val);
    coin_valid = 1'b1;
    coin_value = 8'(val);
    step();
    clear_inputs();
  endtask

  task automatic select(input logic [3:0] s);
    sel_valid = 1'b1;
    sel       = s;
    step();
    clear_inputs();
  endtask

  // Walk the hopper handshake coin by coin against an expected payout list
  task automatic pay_change(input string tag, input int unsigned start_credit,
                            input int unsigned coins[8], input int n);
    int unsigned cr;
    int w;
    cr = start_credit;
    for (int i = 0; i < n; i++) begin
      w = 0;
      while (!chg_req && w < 20) begin
        step();
        w++;
      end
      chk({tag, ".req_seen"}, i, 32'(chg_req), 32'd1);
      if (i > 0) chk({tag, ".gap_cycles"}, i, 32'(w), 32'd1);
      chk({tag, ".chg_value"}, i, 32'(chg_value), 32'(coins[i]));
      chk({tag, ".credit_pre"}, i, 32'(credit), 32'(cr));
      chg_ack = 1'b1;
      step();
      clear_inputs();
      cr = cr - coins[i];
      chk({tag, ".credit_post"}, i, 32'(credit), 32'(cr));
      chk({tag, ".req_drop"}, i, 32'(chg_req), 32'd0);
    end
    step();
    chk({tag, ".busy_end"}, n, 32'(busy), 32'd0);
    chk({tag, ".credit_end"}, n, 32'(credit), 32'd0);
  endtask

`ifdef VEND_STOCK_EN
  task automatic do_restock();
    restock = 1'b1;
    step();
    clear_inputs();
  endtask
`endif

  initial begin
    int n;
    int cnt;
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.credit", 0, 32'(credit), 32'd0);
    chk("rst.coin_reject", 0, 32'(coin_reject), 32'd0);
    chk("rst.sel_error", 0, 32'(sel_error), 32'd0);
    chk("rst.disp_req", 0, 32'(disp_req), 32'd0);
    chk("rst.chg_req", 0, 32'(chg_req), 32'd0);
    chk("rst.busy", 0, 32'(busy), 32'd0);
    chk("rst.fault", 0, 32'(fault), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // cv cval sv sel can dd ack | credit rej serr dreq slot creq cval busy fault
    add(0, 0, 0,4'b0000,0,0,0,   0,0,0,0,0,0, 0,0,0);
    add(1,10, 0,4'b0000,0,0,0,  10,0,0,0,0,0, 0,0,0);
    add(1, 5, 0,4'b0000,0,0,0,  15,0,0,0,0,0, 0,0,0);
    add(0, 0, 1,4'b0010,0,0,0,   0,0,0,1,1,0, 0,1,0);
    add(0, 0, 0,4'b0000,0,0,0,   0,0,0,1,1,0, 0,1,0);
    add(0, 0, 0,4'b0000,0,1,0,   0,0,0,0,0,0, 0,0,0);
    add(0, 0, 0,4'b0000,0,0,0,   0,0,0,0,0,0, 0,0,0);
    add(1,50, 0,4'b0000,0,0,0,  50,0,0,0,0,0, 0,0,0);
    add(0, 0, 1,4'b0001,0,0,0,  40,0,0,1,0,0, 0,1,0);
    add(0, 0, 0,4'b0000,0,1,0,  40,0,0,0,0,0, 0,1,0);
    add(0, 0, 0,4'b0000,0,0,0,  40,0,0,0,0,1,10,1,0);
    add(0, 0, 0,4'b0000,0,0,1,  30,0,0,0,0,0, 0,1,0);
    add(0, 0, 0,4'b0000,0,0,0,  30,0,0,0,0,1,10,1,0);
    add(0, 0, 0,4'b0000,0,0,1,  20,0,0,0,0,0, 0,1,0);
    add(0, 0, 0,4'b0000,0,0,0,  20,0,0,0,0,1,10,1,0);
    add(0, 0, 0,4'b0000,0,0,1,  10,0,0,0,0,0, 0,1,0);
    add(0, 0, 0,4'b0000,0,0,0,  10,0,0,0,0,1,10,1,0);
    add(0, 0, 0,4'b0000,0,0,1,   0,0,0,0,0,0, 0,1,0);
    add(0, 0, 0,4'b0000,0,0,0,   0,0,0,0,0,0, 0,0,0);
    add(1,10, 0,4'b0000,0,0,0,  10,0,0,0,0,0, 0,0,0);
    add(0, 0, 1,4'b1000,0,0,0,  10,0,1,0,0,0, 0,0,0);
    add(0, 0, 1,4'b0011,0,0,0,  10,0,1,0,0,0, 0,0,0);
    add(1, 3, 0,4'b0000,0,0,0,  10,1,0,0,0,0, 0,0,0);
    add(0, 0, 1,4'b0001,1,0,0,  10,0,0,0,0,0, 0,1,0);
    add(0, 0, 0,4'b0000,0,0,1,  10,0,0,0,0,1,10,1,0);
    add(0, 0, 0,4'b0000,0,0,1,   0,0,0,0,0,0, 0,1,0);
    add(0, 0, 0,4'b0000,0,0,0,   0,0,0,0,0,0, 0,0,0);
    add(1,10, 0,4'b0000,0,0,0,  10,0,0,0,0,0, 0,0,0);
    add(1,10, 0,4'b0000,0,0,0,  20,0,0,0,0,0, 0,0,0);
    add(1, 5, 1,4'b0100,0,0,0,   5,0,0,1,2,0, 0,1,0);
    add(0, 0, 0,4'b0000,0,1,0,   5,0,0,0,0,0, 0,1,0);
    add(0, 0, 0,4'b0000,0,0,0,   5,0,0,0,0,1, 5,1,0);
    add(0, 0, 0,4'b0000,0,0,1,   0,0,0,0,0,0, 0,1,0);
    add(0, 0, 0,4'b0000,0,0,0,   0,0,0,0,0,0, 0,0,0);
    add(0, 0, 0,4'b0000,0,1,0,   0,0,0,0,0,0, 0,0,0);
    add(0, 0, 1,4'b0001,0,0,0,   0,0,0,0,0,0, 0,0,0);

    foreach (tbl[i]) begin
      coin_valid = tbl[i].cv;
      coin_value = tbl[i].cval;
      sel_valid  = tbl[i].sv;
      sel        = tbl[i].s;
      cancel     = tbl[i].can;
      disp_done  = tbl[i].dd;
      chg_ack    = tbl[i].ack;
      step();
      clear_inputs();
      chk("vec.credit", i, 32'(credit), 32'(tbl[i].e_credit));
      chk("vec.coin_reject", i, 32'(coin_reject), 32'(tbl[i].e_rej));
      chk("vec.sel_error", i, 32'(sel_error), 32'(tbl[i].e_serr));
      chk("vec.disp_req", i, 32'(disp_req), 32'(tbl[i].e_dreq));
      if (tbl[i].e_dreq) chk("vec.disp_slot", i, 32'(disp_slot), 32'(tbl[i].e_slot));
      chk("vec.chg_req", i, 32'(chg_req), 32'(tbl[i].e_creq));
      if (tbl[i].e_creq) chk("vec.chg_value", i, 32'(chg_value), 32'(tbl[i].e_cval));
      chk("vec.busy", i, 32'(busy), 32'(tbl[i].e_busy));
      chk("vec.fault", i, 32'(fault), 32'(tbl[i].e_fault));
    end

    // Credit ceiling: 255 reachable, anything past it rejected
    for (int k = 1; k <= 5; k++) begin
      coin(50);
      chk("ovf.credit", k, 32'(credit), 32'(50 * k));
      chk("ovf.reject", k, 32'(coin_reject), 32'd0);
    end
    coin(10);
    chk("ovf.reject10", 0, 32'(coin_reject), 32'd1);
    chk("ovf.credit10", 0, 32'(credit), 32'd250);
    coin(5);
    chk("ovf.credit255", 0, 32'(credit), 32'd255);
    coin(1);
    chk("ovf.reject1", 0, 32'(coin_reject), 32'd1);
    chk("ovf.credit1", 0, 32'(credit), 32'd255);
    cancel = 1'b1;
    step();
    clear_inputs();
    chk("ovf.busy", 0, 32'(busy), 32'd1);
    pay_change("ovf", 255, '{50, 50, 50, 50, 50, 5, 0, 0}, 6);

`ifdef VEND_STOCK_EN
    do_restock();
`endif

    // Dispenser never answers: fault on cycle 255, price refunded; coin during DISPENSE rejected
    coin(50);
    select(4'b0100);
    chk("tmo.disp_req", 0, 32'(disp_req), 32'd1);
    chk("tmo.slot", 0, 32'(disp_slot), 32'd2);
    chk("tmo.credit", 0, 32'(credit), 32'd30);
    n = 0;
    cnt = 0;
    while (n < 300) begin
      if (n == 10) begin
        coin_valid = 1'b1;
        coin_value = 8'd5;
      end
      step();
      clear_inputs();
      n++;
      if (n == 11) begin
        chk("tmo.coin_reject", n, 32'(coin_reject), 32'd1);
        chk("tmo.coin_credit", n, 32'(credit), 32'd30);
      end
      if (fault) break;
      if (!disp_req) cnt++;
    end
    chk("tmo.fault_cycle", 0, 32'(n), 32'd255);
    chk("tmo.req_held", 0, 32'(cnt), 32'd0);
    chk("tmo.req_drop", 0, 32'(disp_req), 32'd0);
    chk("tmo.refund", 0, 32'(credit), 32'd50);
    chk("tmo.busy", 0, 32'(busy), 32'd1);
    step();
    chk("tmo.fault_pulse", 0, 32'(fault), 32'd0);
    pay_change("tmo", 50, '{50, 0, 0, 0, 0, 0, 0, 0}, 1);

    // disp_done in the timeout cycle counts as done
    coin(10);
    select(4'b0001);
    chk("edge.disp_req", 0, 32'(disp_req), 32'd1);
    chk("edge.credit", 0, 32'(credit), 32'd0);
    n = 0;
    cnt = 0;
    while (n < 254) begin
      step();
      n++;
      if (fault || !disp_req) cnt++;
    end
    disp_done = 1'b1;
    step();
    clear_inputs();
    chk("edge.early", 0, 32'(cnt), 32'd0);
    chk("edge.fault", 0, 32'(fault), 32'd0);
    chk("edge.disp_req", 1, 32'(disp_req), 32'd0);
    chk("edge.busy", 0, 32'(busy), 32'd0);
    step();
    chk("edge.fault_late", 0, 32'(fault), 32'd0);

    // Asynchronous reset in the middle of a payout
    coin(10);
    cancel = 1'b1;
    step();
    clear_inputs();
    cnt = 0;
    while (!chg_req && cnt < 20) begin
      step();
      cnt++;
    end
    chk("arst.req_before", 0, 32'(chg_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.chg_req", 0, 32'(chg_req), 32'd0);
    chk("arst.chg_value", 0, 32'(chg_value), 32'd0);
    chk("arst.credit", 0, 32'(credit), 32'd0);
    chk("arst.busy", 0, 32'(busy), 32'd0);
    chk("arst.disp_req", 0, 32'(disp_req), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("arst.credit_after", 0, 32'(credit), 32'd0);
    chk("arst.chg_req_after", 0, 32'(chg_req), 32'd0);
    chk("arst.busy_after", 0, 32'(busy), 32'd0);

`ifdef VEND_STOCK_EN
    // One unit of stock: second purchase of slot 0 refused, restock clears it
    do_restock();
    coin(10);
    select(4'b0001);
    chk("stk.disp_req", 0, 32'(disp_req), 32'd1);
    disp_done = 1'b1;
    step();
    clear_inputs();
    chk("stk.busy", 0, 32'(busy), 32'd0);
    chk("stk.sold_out", 0, 32'(sold_out[0]), 32'd1);
    coin(10);
    select(4'b0001);
    chk("stk.sel_error", 0, 32'(sel_error), 32'd1);
    chk("stk.disp_req", 1, 32'(disp_req), 32'd0);
    chk("stk.credit", 0, 32'(credit), 32'd10);
    do_restock();
    chk("stk.sold_out", 1, 32'(sold_out[0]), 32'd0);
    cancel = 1'b1;
    step();
    clear_inputs();
    pay_change("stk", 10, '{10, 0, 0, 0, 0, 0, 0, 0}, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
